// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control and fetch-address bundle between branch/trap logic and pc_unit
interface pc_unit_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  logic                           stall;
  logic                           redirect_valid;
  logic [XLEN-1:0]                redirect_target;
  logic                           trap_valid;
  logic [XLEN-1:0]                trap_vector;
  logic                           call_valid;
  logic [XLEN-1:0]                call_target;
  logic                           ret_valid;
  logic [XLEN-1:0]                current_pc;
  logic [XLEN-1:0]                pc_plus;
  logic                           misaligned;
  logic                           ras_overflow;
  logic                           ras_underflow;
  logic [$clog2(RAS_DEPTH):0]     ras_count;

  modport master (
    output stall, redirect_valid, redirect_target, trap_valid, trap_vector,
           call_valid, call_target, ret_valid,
    input  current_pc, pc_plus, misaligned, ras_overflow, ras_underflow, ras_count
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap_valid, trap_vector,
           call_valid, call_target, ret_valid,
    output current_pc, pc_plus, misaligned, ras_overflow, ras_underflow, ras_count
  );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with prioritised next-PC select and circular return-address stack
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  pc_unit_if.slave   bus
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [CW-1:0]   FULL     = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [AW-1:0]   ras_ptr;
  logic [CW-1:0]   ras_cnt;
  logic            mis_q, ovf_q, udf_q;

  logic [XLEN-1:0] next_pc, raw_tgt, ras_top;
  logic            load_tgt, push, pop, replace, ovf_d, udf_d;

  assign pc_plus = pc_q + XLEN'(INSTR_BYTES);
  // ras_ptr names the next free slot, so the top of stack sits one below it
  assign ras_top = ras_mem[ras_ptr - 1'b1];

  always_comb begin
    next_pc  = pc_plus;
    raw_tgt  = '0;
    load_tgt = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    replace  = 1'b0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (bus.trap_valid) begin
      raw_tgt  = bus.trap_vector;
      load_tgt = 1'b1;
    end else if (bus.redirect_valid) begin
      raw_tgt  = bus.redirect_target;
      load_tgt = 1'b1;
    end else if (bus.stall) begin
      next_pc = pc_q;
    end else if (bus.call_valid && bus.ret_valid) begin
      raw_tgt  = bus.call_target;
      load_tgt = 1'b1;
      if (ras_cnt == '0) begin
        push  = 1'b1;
        udf_d = 1'b1;
      end else begin
        replace = 1'b1;
      end
    end else if (bus.call_valid) begin
      raw_tgt  = bus.call_target;
      load_tgt = 1'b1;
      push     = 1'b1;
      ovf_d    = (ras_cnt == FULL);
    end else if (bus.ret_valid) begin
      if (ras_cnt != '0) begin
        raw_tgt  = ras_top;
        load_tgt = 1'b1;
        pop      = 1'b1;
      end else begin
        udf_d = 1'b1;
      end
    end
    if (load_tgt) next_pc = raw_tgt & ~LOW_MASK;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else begin
      pc_q  <= next_pc;
      mis_q <= load_tgt && ((raw_tgt & LOW_MASK) != '0);
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      if (push) begin
        ras_ptr <= ras_ptr + 1'b1;
        if (ras_cnt != FULL) ras_cnt <= ras_cnt + 1'b1;
      end else if (pop) begin
        ras_ptr <= ras_ptr - 1'b1;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

  // Stack storage is not reset; entries beyond ras_cnt are never read
  always_ff @(posedge clk) begin
    if (reset) begin
      if (push)         ras_mem[ras_ptr]        <= pc_plus;
      else if (replace) ras_mem[ras_ptr - 1'b1] <= pc_plus;
    end
  end

  assign bus.current_pc    = pc_q;
  assign bus.pc_plus       = pc_plus;
  assign bus.misaligned    = mis_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = udf_q;
  assign bus.ras_count     = ras_cnt;
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pc_unit_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0), .INSTR_BYTES(4), .RAS_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.trap_valid      = 1'b0;
    bus.trap_vector     = '0;
    bus.call_valid      = 1'b0;
    bus.call_target     = '0;
    bus.ret_valid       = 1'b0;
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] exp);
    checks++;
    assert (bus.current_pc === exp) else begin
      errors++;
      $error("FAIL %s: current_pc=%h expected=%h", tag, bus.current_pc, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [2:0] exp);
    checks++;
    assert (bus.ras_count === exp) else begin
      errors++;
      $error("FAIL %s: ras_count=%0d expected=%0d", tag, bus.ras_count, exp);
    end
  endtask

  // flags packed as {misaligned, ras_overflow, ras_underflow}
  task automatic chk_flg(input string tag, input logic [2:0] exp);
    checks++;
    assert ({bus.misaligned, bus.ras_overflow, bus.ras_underflow} === exp) else begin
      errors++;
      $error("FAIL %s: flags(mis,ovf,udf)=%b expected=%b", tag,
             {bus.misaligned, bus.ras_overflow, bus.ras_underflow}, exp);
    end
  endtask

  task automatic chk_plus(input string tag, input logic [31:0] exp);
    checks++;
    assert (bus.pc_plus === exp) else begin
      errors++;
      $error("FAIL %s: pc_plus=%h expected=%h", tag, bus.pc_plus, exp);
    end
  endtask

  initial begin
    clr();
    reset = 1'b0;
    tick(); tick();
    chk_pc("reset_pc", 32'h0);
    chk_flg("reset_flags", 3'b000);
    chk_cnt("reset_cnt", 3'd0);

    reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk_pc($sformatf("inc_%0d", i), 32'(i * 4));
    end
    chk_plus("plus_1c", 32'h20);
    chk_flg("inc_flags", 3'b000);

    reset = 1'b0; tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_pc("pre_midreset", 32'h10);
    reset = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h200;
    tick();
    chk_pc("mid_reset_overrides", 32'h0);
    clr();
    reset = 1'b1;

    tick(); tick();
    chk_pc("pre_stall", 32'h8);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pc($sformatf("stall_%0d", i), 32'h8);
    end
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h100;
    tick();
    chk_pc("stall_redirect", 32'h100);
    bus.redirect_valid = 1'b0;
    tick();
    chk_pc("stall_hold_after_redirect", 32'h100);
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h200;
    bus.trap_valid = 1'b1; bus.trap_vector = 32'h80;
    tick();
    chk_pc("trap_beats_redirect", 32'h80);
    bus.redirect_valid = 1'b0; bus.trap_valid = 1'b0;
    tick();
    chk_pc("stall_hold_after_trap", 32'h80);
    clr();

    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h20;
    tick(); clr();
    bus.call_valid = 1'b1; bus.call_target = 32'h400;
    tick();
    chk_pc("call1_pc", 32'h400);
    chk_cnt("call1_cnt", 3'd1);
    clr(); tick();
    chk_pc("step_404", 32'h404);
    bus.call_valid = 1'b1; bus.call_target = 32'h800;
    tick();
    chk_pc("call2_pc", 32'h800);
    chk_cnt("call2_cnt", 3'd2);
    clr(); bus.ret_valid = 1'b1;
    tick();
    chk_pc("ret1_pc", 32'h408);
    chk_cnt("ret1_cnt", 3'd1);
    tick();
    chk_pc("ret2_pc", 32'h24);
    chk_cnt("ret2_cnt", 3'd0);
    chk_flg("ret2_flags", 3'b000);
    clr();

    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h0;
    tick(); clr();
    for (int i = 0; i < 5; i++) begin
      bus.call_valid = 1'b1; bus.call_target = 32'((i + 1) * 16);
      tick();
      chk_pc($sformatf("fill_pc_%0d", i), 32'((i + 1) * 16));
      chk_cnt($sformatf("fill_cnt_%0d", i), (i < 4) ? 3'(i + 1) : 3'd4);
      chk_flg($sformatf("fill_flg_%0d", i), (i == 4) ? 3'b010 : 3'b000);
    end
    clr(); bus.ret_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_pc($sformatf("drain_pc_%0d", i), 32'(32'h44 - i * 16));
      chk_cnt($sformatf("drain_cnt_%0d", i), 3'(3 - i));
      chk_flg($sformatf("drain_flg_%0d", i), 3'b000);
    end
    tick();
    chk_pc("underflow_pc", 32'h18);
    chk_flg("underflow_flag", 3'b001);
    chk_cnt("underflow_cnt", 3'd0);
    clr(); tick();
    chk_pc("after_underflow_pc", 32'h1C);
    chk_flg("underflow_pulse_end", 3'b000);

    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h103;
    tick();
    chk_pc("misalign_pc", 32'h100);
    chk_flg("misalign_flag", 3'b100);
    clr(); tick();
    chk_pc("misalign_next", 32'h104);
    chk_flg("misalign_pulse_end", 3'b000);
    bus.trap_valid = 1'b1; bus.trap_vector = 32'h82;
    tick();
    chk_pc("trap_misalign_pc", 32'h80);
    chk_flg("trap_misalign_flag", 3'b100);
    clr();
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    chk_pc("wrap_top", 32'hFFFF_FFFC);
    chk_plus("wrap_plus", 32'h0);
    clr(); tick();
    chk_pc("wrap_pc", 32'h0);
    chk_flg("wrap_flags", 3'b000);

    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h20;
    tick(); clr();
    bus.call_valid = 1'b1; bus.call_target = 32'h50;
    tick();
    chk_pc("sim_setup_pc", 32'h50);
    chk_cnt("sim_setup_cnt", 3'd1);
    bus.ret_valid = 1'b1; bus.call_target = 32'h600;
    tick();
    chk_pc("callret_pc", 32'h600);
    chk_cnt("callret_cnt", 3'd1);
    chk_flg("callret_flags", 3'b000);
    clr(); bus.ret_valid = 1'b1;
    tick();
    chk_pc("callret_top", 32'h54);
    chk_cnt("callret_pop_cnt", 3'd0);
    bus.call_valid = 1'b1; bus.call_target = 32'h700;
    tick();
    chk_pc("callret_empty_pc", 32'h700);
    chk_cnt("callret_empty_cnt", 3'd1);
    chk_flg("callret_empty_udf", 3'b001);
    bus.call_valid = 1'b0;
    tick();
    chk_pc("callret_empty_top", 32'h58);
    chk_cnt("callret_empty_pop", 3'd0);
    clr();
    bus.stall = 1'b1; bus.call_valid = 1'b1; bus.call_target = 32'h900;
    tick();
    chk_pc("stall_blocks_call_pc", 32'h58);
    chk_cnt("stall_blocks_call_cnt", 3'd0);
    clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
